// File: rtl/cond_unit.sv
// Condition-evaluation unit: holds NZCV, evaluates issued condition codes against it,
// gates register/memory/PC writes, and stalls issue until pending ALU flags arrive.
module cond_unit #(
  parameter logic [3:0] FLAGS_RESET = 4'b0000,
  parameter logic       NV_EXEC     = 1'b0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] cond,
  input  logic [1:0] flagw,
  input  logic       regw,
  input  logic       memw,
  input  logic       pcs,
  input  logic       alu_valid,
  input  logic [3:0] aluflags,
  output logic       out_valid,
  output logic       condex,
  output logic       regwrite,
  output logic       memwrite,
  output logic       pcsrc,
  output logic [3:0] flags
);

  localparam int unsigned FLAG_W = 4;
  localparam int unsigned MASK_W = 2;

  typedef enum logic {
    IDLE       = 1'b0,
    WAIT_FLAGS = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [FLAG_W-1:0]   flags_q, flags_d;
  logic [MASK_W-1:0]   mask_q, mask_d;
  logic                out_valid_q, out_valid_d;
  logic                condex_q, condex_d;
  logic                regwrite_q, regwrite_d;
  logic                memwrite_q, memwrite_d;
  logic                pcsrc_q, pcsrc_d;

  logic                accept_c;
  logic                cond_ok_c;
  logic                f_n, f_z, f_c, f_v;

  assign f_n = flags_q[3];
  assign f_z = flags_q[2];
  assign f_c = flags_q[1];
  assign f_v = flags_q[0];

  // Issue is only possible when no flag update is outstanding.
  assign in_ready = reset_n & (state_q == IDLE);
  assign accept_c = in_valid & in_ready;

  // Condition decode against the registered flags (no aluflags bypass).
  always_comb begin
    cond_ok_c = 1'b0;
    case (cond)
      4'b0000: cond_ok_c = f_z;
      4'b0001: cond_ok_c = ~f_z;
      4'b0010: cond_ok_c = f_c;
      4'b0011: cond_ok_c = ~f_c;
      4'b0100: cond_ok_c = f_n;
      4'b0101: cond_ok_c = ~f_n;
      4'b0110: cond_ok_c = f_v;
      4'b0111: cond_ok_c = ~f_v;
      4'b1000: cond_ok_c = f_c & ~f_z;
      4'b1001: cond_ok_c = ~f_c | f_z;
      4'b1010: cond_ok_c = (f_n == f_v);
      4'b1011: cond_ok_c = (f_n != f_v);
      4'b1100: cond_ok_c = ~f_z & (f_n == f_v);
      4'b1101: cond_ok_c = f_z | (f_n != f_v);
      4'b1110: cond_ok_c = 1'b1;
      default: cond_ok_c = NV_EXEC;
    endcase
  end

  // Next-state, flag update and gated-output logic.
  always_comb begin
    state_d     = state_q;
    flags_d     = flags_q;
    mask_d      = mask_q;
    out_valid_d = accept_c;
    condex_d    = accept_c & cond_ok_c;
    regwrite_d  = accept_c & cond_ok_c & regw;
    memwrite_d  = accept_c & cond_ok_c & memw;
    pcsrc_d     = accept_c & cond_ok_c & pcs;

    case (state_q)
      IDLE: begin
        if (accept_c && cond_ok_c && (flagw != 2'b00)) begin
          state_d = WAIT_FLAGS;
          mask_d  = flagw;
        end
      end
      WAIT_FLAGS: begin
        if (alu_valid) begin
          if (mask_q[1]) flags_d[3:2] = aluflags[3:2];
          if (mask_q[0]) flags_d[1:0] = aluflags[1:0];
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      flags_q     <= FLAGS_RESET;
      mask_q      <= MASK_W'(0);
      out_valid_q <= 1'b0;
      condex_q    <= 1'b0;
      regwrite_q  <= 1'b0;
      memwrite_q  <= 1'b0;
      pcsrc_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      flags_q     <= flags_d;
      mask_q      <= mask_d;
      out_valid_q <= out_valid_d;
      condex_q    <= condex_d;
      regwrite_q  <= regwrite_d;
      memwrite_q  <= memwrite_d;
      pcsrc_q     <= pcsrc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign condex    = condex_q;
  assign regwrite  = regwrite_q;
  assign memwrite  = memwrite_q;
  assign pcsrc     = pcsrc_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_cond_unit.sv
// Bench for cond_unit: directed and random issue/flag traffic checked each cycle
// against a behavioural model of the NZCV register and pending-update stall.
module tb_cond_unit;

  localparam logic [3:0] FLAGS_RESET = 4'b0000;
  localparam logic       NV_EXEC     = 1'b0;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] cond;
  logic [1:0] flagw;
  logic       regw, memw, pcs;
  logic       alu_valid;
  logic [3:0] aluflags;
  logic       out_valid, condex, regwrite, memwrite, pcsrc;
  logic [3:0] flags;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [3:0] m_flags;
  bit         m_wait;
  logic [1:0] m_mask;
  bit         e_ov, e_cx, e_rw, e_mw, e_pc;

  cond_unit #(.FLAGS_RESET(FLAGS_RESET), .NV_EXEC(NV_EXEC)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .cond(cond), .flagw(flagw), .regw(regw), .memw(memw), .pcs(pcs),
    .alu_valid(alu_valid), .aluflags(aluflags), .out_valid(out_valid),
    .condex(condex), .regwrite(regwrite), .memwrite(memwrite), .pcsrc(pcsrc),
    .flags(flags)
  );

  always #5 clock = ~clock;

  // Pairs of codes share a base predicate; the odd code is its complement.
  function automatic bit ref_cond(input logic [3:0] f, input logic [3:0] c);
    int n, z, cy, v, base;
    n = int'(f[3]); z = int'(f[2]); cy = int'(f[1]); v = int'(f[0]);
    if (c == 4'd15) return NV_EXEC;
    case (int'(c) / 2)
      0: base = z;
      1: base = cy;
      2: base = n;
      3: base = v;
      4: base = (cy == 1 && z == 0) ? 1 : 0;
      5: base = (n == v) ? 1 : 0;
      6: base = (z == 0 && n == v) ? 1 : 0;
      default: base = 1;
    endcase
    if (c == 4'd14) return 1'b1;
    return (int'(c) % 2 == 1) ? (base == 0) : (base != 0);
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ":in_ready"},  4'(in_ready),  4'(reset_n && !m_wait));
    check({tag, ":out_valid"}, 4'(out_valid), 4'(e_ov));
    check({tag, ":condex"},    4'(condex),    4'(e_cx));
    check({tag, ":regwrite"},  4'(regwrite),  4'(e_rw));
    check({tag, ":memwrite"},  4'(memwrite),  4'(e_mw));
    check({tag, ":pcsrc"},     4'(pcsrc),     4'(e_pc));
    check({tag, ":flags"},     flags,         m_flags);
  endtask

  task automatic model_reset();
    m_flags = FLAGS_RESET; m_wait = 0; m_mask = 2'b00;
    e_ov = 0; e_cx = 0; e_rw = 0; e_mw = 0; e_pc = 0;
  endtask

  // Advance one clock: model consumes current inputs, DUT checked #1 after the edge.
  task automatic tick(input string tag);
    bit acc, ok;
    acc = in_valid && !m_wait;
    ok  = ref_cond(m_flags, cond);
    e_ov = acc; e_cx = acc && ok;
    e_rw = e_cx && regw; e_mw = e_cx && memw; e_pc = e_cx && pcs;
    if (m_wait) begin
      if (alu_valid) begin
        if (m_mask[1]) m_flags[3:2] = aluflags[3:2];
        if (m_mask[0]) m_flags[1:0] = aluflags[1:0];
        m_wait = 0;
      end
    end else if (acc && ok && flagw != 2'b00) begin
      m_wait = 1; m_mask = flagw;
    end
    @(posedge clock); #1;
    check_all(tag);
  endtask

  task automatic drive(input bit v, input logic [3:0] c, input logic [1:0] fw,
                       input bit r, input bit m, input bit p,
                       input bit av, input logic [3:0] af);
    in_valid = v; cond = c; flagw = fw; regw = r; memw = m; pcs = p;
    alu_valid = av; aluflags = af;
  endtask

  task automatic idle_in();
    drive(0, 4'd0, 2'b00, 0, 0, 0, 0, 4'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    idle_in();
    model_reset();
    #12;
    check_all("reset");
    @(posedge clock); #1;
    reset_n = 1'b1;

    // AL with regw, no flag write
    drive(1, 4'b1110, 2'b00, 1, 0, 0, 0, 4'd0);
    tick("al_regw");
    idle_in(); tick("idle1");

    // EQ fails with flags=0000: no wait, flags unchanged
    drive(1, 4'b0000, 2'b11, 1, 1, 1, 0, 4'd0);
    tick("eq_fail");
    // AL flagw=11 then ALU returns 0100
    drive(1, 4'b1110, 2'b11, 0, 0, 0, 0, 4'd0);
    tick("al_fw11");
    drive(1, 4'b1110, 2'b00, 1, 0, 0, 1, 4'b0100);
    tick("alu_0100");
    drive(1, 4'b0000, 2'b00, 0, 1, 0, 0, 4'd0);
    tick("eq_memw");

    // Preload 1000, then flagw=01 with aluflags=0111 -> 1011
    drive(1, 4'b1110, 2'b11, 0, 0, 0, 0, 4'd0); tick("pre_fw11");
    drive(0, 4'd0, 2'b00, 0, 0, 0, 1, 4'b1000); tick("pre_1000");
    drive(1, 4'b1110, 2'b01, 0, 0, 1, 0, 4'd0); tick("al_fw01");
    drive(0, 4'd0, 2'b00, 0, 0, 0, 1, 4'b0111); tick("alu_0111");
    idle_in(); tick("idle2");

    // Stall for 5 cycles with in_valid held high
    drive(1, 4'b1110, 2'b10, 1, 0, 0, 0, 4'd0); tick("stall_issue");
    for (int i = 0; i < 5; i++) begin
      drive(1, 4'b1110, 2'b00, 1, 1, 1, 0, 4'hF);
      tick("stall");
    end
    drive(1, 4'b1110, 2'b00, 1, 1, 1, 1, 4'b0010); tick("stall_release");
    drive(1, 4'b1110, 2'b00, 1, 1, 1, 0, 4'd0); tick("post_release");

    // Full condition sweep over every NZCV value
    for (int f = 0; f < 16; f++) begin
      drive(1, 4'b1110, 2'b11, 0, 0, 0, 0, 4'd0); tick("sweep_set");
      drive(0, 4'd0, 2'b00, 0, 0, 0, 1, 4'(f)); tick("sweep_alu");
      for (int c = 0; c < 16; c++) begin
        drive(1, 4'(c), 2'b00, 1, $urandom_range(0, 1), $urandom_range(0, 1), 0, 4'd0);
        tick("sweep_cond");
      end
    end

    // Random traffic, including alu_valid in IDLE and stray in_valid in WAIT
    reset_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 4'($urandom), 2'($urandom),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 2) == 0, 4'($urandom));
      tick("random");
    end

    // Make flags non-reset, then reset in the middle of WAIT_FLAGS
    idle_in();
    while (m_wait) begin
      alu_valid = 1; aluflags = 4'b1010; tick("drain");
    end
    drive(1, 4'b1110, 2'b11, 0, 0, 0, 0, 4'd0); tick("rst_pre_set");
    drive(0, 4'd0, 2'b00, 0, 0, 0, 1, 4'b1101); tick("rst_pre_alu");
    drive(1, 4'b1110, 2'b11, 1, 1, 1, 0, 4'd0); tick("rst_enter_wait");
    drive(0, 4'd0, 2'b00, 0, 0, 0, 1, 4'b0110);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("rst_mid_wait");
    @(posedge clock); #1;
    check_all("rst_held");
    reset_n = 1'b1;
    idle_in();
    #1;
    check_all("rst_release");
    drive(1, 4'b1110, 2'b00, 1, 0, 1, 0, 4'd0); tick("post_rst_issue");
    idle_in(); tick("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Consumer end of the ALU flag interface. Holds the architectural NZCV register and takes the `aluflags` the ALU produces.
- Evaluates each issued instruction's 4-bit condition field against NZCV and gates its register, memory and PC writes.
- Sits between decode (issue side) and the ALU (flag side). Stalls issue while a flag-setting instruction's flags are still outstanding.

Parameters:
- FLAGS_RESET, 4'b0000, value of the NZCV register after reset.
- NV_EXEC, 1'b0, execute result for cond=4'b1111 (0 = never execute, 1 = always execute).

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  decode presents an instruction.
- in_ready  output  1  unit can accept an instruction this cycle.
- cond  input  4  instruction bits [31:28].
- flagw  input  2  [1] = update N,Z; [0] = update C,V.
- regw  input  1  unconditioned register-write request.
- memw  input  1  unconditioned memory-write request.
- pcs  input  1  unconditioned PC-write request.
- alu_valid  input  1  `aluflags` is valid this cycle.
- aluflags  input  4  [3]=N, [2]=Z, [1]=C, [0]=V from the ALU.
- out_valid  output  1  gated outputs are valid.
- condex  output  1  registered condition result.
- regwrite  output  1  regw & condex, registered.
- memwrite  output  1  memw & condex, registered.
- pcsrc  output  1  pcs & condex, registered.
- flags  output  4  current NZCV register.

Behaviour:
- Reset (async, reset_n=0):
  - flags = FLAGS_RESET.
  - state = IDLE.
  - out_valid, condex, regwrite, memwrite, pcsrc = 0.
  - in_ready = 0 while reset_n=0.
  - A reset in mid-WAIT_FLAGS abandons the pending update; flags returns to FLAGS_RESET.
- States: IDLE, WAIT_FLAGS.
- in_ready = 1 in IDLE, 0 in WAIT_FLAGS (combinational from state, reset-gated).
- Accept = in_valid & in_ready.
- Condition evaluation is combinational on the flags register value at the accept edge. Codes, with N,Z,C,V = flags[3:0]:
  - 0000 EQ: Z. 0001 NE: !Z.
  - 0010 CS: C. 0011 CC: !C.
  - 0100 MI: N. 0101 PL: !N.
  - 0110 VS: V. 0111 VC: !V.
  - 1000 HI: C&!Z. 1001 LS: !C|Z.
  - 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: !Z&(N==V). 1101 LE: Z|(N!=V).
  - 1110 AL: 1. 1111: NV_EXEC.
- Accept at edge T:
  - Cycle T+1: out_valid=1; condex and the gated writes reflect that instruction.
  - With no accept, out_valid=0 next cycle and the gated outputs are 0.
  - Latency is exactly 1 cycle.
- Transition to WAIT_FLAGS: on accept when condex=1 and flagw!=2'b00. Latch flagw into a pending mask.
- A failed condition or flagw=00 stays in IDLE. A failed flag-setting instruction never waits and never updates flags.
- In WAIT_FLAGS, on a rising edge with alu_valid=1:
  - flags[3:2] <= aluflags[3:2] if mask[1].
  - flags[1:0] <= aluflags[1:0] if mask[0].
  - Unmasked bits hold.
  - Return to IDLE; in_ready=1 in the next cycle.
- alu_valid in IDLE is ignored; flags do not change.
- in_valid during WAIT_FLAGS is not accepted; the upstream stage holds the instruction.
- Flags updated at edge E are the ones used to evaluate any instruction accepted at E+1 or later. There is no bypass of `aluflags` into the evaluation.
- The `flags` output is the register value; it changes only at update edges or on reset.
- Back-to-back flag-setting instructions: the minimum issue spacing is 2 cycles (accept, then alu_valid in the next cycle).

Test Plan:
- Reset, then drive in_valid=1, cond=1110, regw=1, flagw=00 → at T+1: out_valid=1, condex=1, regwrite=1; flags=0000; in_ready stays 1.
- Issue cond=0000 (EQ), flagw=11 with flags=0000 → condex=0, no wait state, in_ready=1, flags unchanged. Then issue AL, flagw=11 and drive alu_valid=1, aluflags=0100 one cycle later → flags=0100. A following EQ, memw=1 gives memwrite=1.
- Issue AL, flagw=01 with flags=1000, then alu_valid with aluflags=0111 → flags=1011 (N,Z held; C,V written). in_ready is 0 for exactly the wait cycles.
- Hold alu_valid=0 for 5 cycles after a flag-setting issue while in_valid=1 → in_ready=0 for those 5 cycles, no accepts. Then alu_valid=1 → in_ready=1 on the next cycle.
- Sweep all 16 conds against the 16 NZCV values (flags preloaded via AL+flagw=11) → condex matches the table; 1111 gives 0 with NV_EXEC=0.
- Assert reset_n=0 mid-WAIT_FLAGS while alu_valid=1 → flags=FLAGS_RESET immediately, outputs 0. After release, state is IDLE and in_ready=1.
